exc_req_gen: RTL and testbench
==============================

EXC_REQ_GEN -- requirements
Module: exc_req_gen

Interface
REQ-001 SHALL have parameter MAX_NEST, default 3, meaning maximum exception nesting depth (1..7).
REQ-002 SHALL have parameter INT_W, default 4, meaning number of external interrupt lines.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- int_req  in  INT_W  external interrupt lines, level.
- sys_ex, unimpl_ex, ovf_ex  in  1 each  EX-stage exception flags.
- eret  in  1  eret in EX stage.
- ex_pc  in  32  PC of EX instruction.
- nxt_pc  in  32  PC of oldest uncompleted instruction.
- status_in  in  32  CP0 Status; bit 0 = IE.
- cp_signal  out  4  one-hot to CP0: [0] INT, [1] Sys, [2] Unimpl, [3] Ovf.
- epc_wr  out  1  EPC write strobe.
- epc_val  out  32  EPC write data.
- flush  out  1  pipeline flush.
- pc_sel  out  2  00 sequential, 01 handler vector, 10 EPC return.
- int_ack  out  INT_W  one-hot ack of serviced line.
- depth  out  3  current nesting depth.
- nest_err  out  1  sticky nesting overflow / spurious-eret flag.

Function
REQ-004 All outputs SHALL be registered, asserted the cycle after the triggering input sample.
REQ-005 Each int_req bit SHALL be sampled via a 2-flop synchronizer; a rising edge SHALL set that pending bit.
REQ-006 A pending bit SHALL clear only on the cycle its int_ack is asserted; a new edge that cycle SHALL keep it set.
REQ-007 Priority SHALL be ovf_ex > unimpl_ex > sys_ex > interrupt; among pending interrupts, lowest index wins.
REQ-008 An interrupt SHALL be taken only in IDLE with status_in[0]=1 and depth=0.
REQ-009 FSM states SHALL be IDLE, TAKE, SERVICE, RETURN.
REQ-010 IDLE or SERVICE -> TAKE on any synchronous exception; IDLE -> TAKE on an eligible interrupt.
REQ-011 TAKE SHALL last exactly one cycle: cp_signal one-hot of the winning cause, epc_wr=1, flush=1, pc_sel=01, depth+1; then -> SERVICE.
REQ-012 epc_val SHALL be ex_pc for synchronous exceptions and nxt_pc for interrupts; int_ack SHALL pulse with TAKE for interrupts only.
REQ-013 SERVICE -> RETURN on eret; RETURN SHALL last one cycle: flush=1, pc_sel=10, depth-1; then -> SERVICE if depth>0 after decrement, else IDLE.
REQ-014 Exception and eret in the same cycle: exception SHALL win and the eret SHALL be dropped.
REQ-015 Exception at depth=MAX_NEST SHALL not be taken; nest_err SHALL set and the FSM SHALL stay in SERVICE.
REQ-016 eret in IDLE SHALL be ignored and SHALL set nest_err.
REQ-017 Outside TAKE/RETURN, cp_signal=0, epc_wr=0, flush=0, pc_sel=00, int_ack=0.
REQ-018 More than one exception flag in a cycle SHALL yield exactly one cp_signal bit.

Reset
REQ-019 On rst low, asynchronously: state=IDLE, pending=0, synchronizers=0, depth=0, nest_err=0, all outputs 0.
REQ-020 Reset asserted during TAKE or RETURN SHALL abort it with no residual pulse after release.

Structure
REQ-021 FSM state encoding, cause bit indices, and pc_sel codes SHALL reside in the shared control-encode define package.
REQ-022 One sub-module exc_int_sync (synchronizer, edge detect, pending latch per line) SHALL be instantiated INT_W times.

Verification
REQ-023 ovf_ex=1, ex_pc=0x0040_0010 in IDLE -> next cycle cp_signal=4'b1000, epc_wr=1, epc_val=0x0040_0010, flush=1, pc_sel=01; depth=1.
REQ-024 int_req[2] rises, status_in=1, nxt_pc=0x0040_0020 -> TAKE 3 cycles later: cp_signal=4'b0001, int_ack=4'b0100, epc_val=0x0040_0020.
REQ-025 sys_ex and eret same cycle in SERVICE (depth=1) -> TAKE with cp_signal=4'b0010, depth=2, no RETURN.
REQ-026 With MAX_NEST=3, four back-to-back sys_ex -> three TAKEs, depth=3, nest_err=1; then three erets -> three RETURNs with pc_sel=10, depth=0, IDLE.
REQ-027 int_req[1] rises with status_in=0 -> no TAKE, pending held; status_in=1 later -> TAKE with int_ack=4'b0010.
REQ-028 rst low during TAKE -> all outputs 0 immediately, depth=0, pending cleared.

Source files
------------

// File: rtl/exc_req_gen_pkg.sv
// Shared control encodings for the exception request generator.
package exc_req_gen_pkg;

    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned DEPTH_W = 3;

    // Bit positions inside the one-hot cause vector sent to CP0
    localparam int unsigned CAUSE_INT    = 0;
    localparam int unsigned CAUSE_SYS    = 1;
    localparam int unsigned CAUSE_UNIMPL = 2;
    localparam int unsigned CAUSE_OVF    = 3;

    // Next-PC source select codes
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_VECTOR = 2'b01;
    localparam logic [1:0] PC_EPC    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } exc_state_e;

    // Priority-resolve the synchronous exception flags into one cause bit
    function automatic logic [CAUSE_W-1:0] cause_onehot(input logic ovf,
                                                        input logic unimpl,
                                                        input logic sys);
        logic [CAUSE_W-1:0] oh;
        oh = '0;
        if (ovf) begin
            oh[CAUSE_OVF] = 1'b1;
        end else if (unimpl) begin
            oh[CAUSE_UNIMPL] = 1'b1;
        end else if (sys) begin
            oh[CAUSE_SYS] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/exc_int_sync.sv
// Per-line interrupt front end: 2-flop synchronizer, rising-edge detect, pending latch.
module exc_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic pend_c_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pend_q;
    logic pend_d;
    logic rise_c;

    assign rise_c   = sync2_q & ~prev_q;
    assign pend_c_o = pend_q | rise_c;

    // A fresh edge wins over the ack clearing the latch in the same cycle
    always_comb begin
        pend_d = (pend_q & ~ack_i) | rise_c;
    end

    // Synchronizer chain and pending latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/exc_req_gen.sv
// Exception / interrupt request generator: arbitrates causes, drives CP0 and PC redirect.
module exc_req_gen
    import exc_req_gen_pkg::*;
#(
    parameter int unsigned MAX_NEST = 3,
    parameter int unsigned INT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_W-1:0]   int_req,
    input  logic               sys_ex,
    input  logic               unimpl_ex,
    input  logic               ovf_ex,
    input  logic               eret,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        nxt_pc,
    input  logic [31:0]        status_in,
    output logic [3:0]         cp_signal,
    output logic               epc_wr,
    output logic [31:0]        epc_val,
    output logic               flush,
    output logic [1:0]         pc_sel,
    output logic [INT_W-1:0]   int_ack,
    output logic [2:0]         depth,
    output logic               nest_err
);

    exc_state_e           state_q, state_d;
    logic [CAUSE_W-1:0]   cp_q, cp_d;
    logic                 epc_wr_q, epc_wr_d;
    logic [31:0]          epc_val_q, epc_val_d;
    logic                 flush_q, flush_d;
    logic [1:0]           pc_sel_q, pc_sel_d;
    logic [INT_W-1:0]     int_ack_q, int_ack_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 nest_err_q, nest_err_d;

    logic [INT_W-1:0]     pend_c;
    logic [INT_W-1:0]     int_sel_c;
    logic                 exc_c;
    logic                 int_ok_c;
    logic                 nest_full_c;
    logic                 do_exc_c;
    logic                 do_int_c;
    logic                 unused_status_c;

    // One synchronizer/pending slice per interrupt line
    for (genvar g = 0; g < INT_W; g++) begin : g_int
        exc_int_sync u_sync (
            .clk      (clk),
            .rst      (rst),
            .req_i    (int_req[g]),
            .ack_i    (int_ack_q[g]),
            .pend_c_o (pend_c[g])
        );
    end

    assign unused_status_c = ^status_in[31:1];
    assign exc_c           = ovf_ex | unimpl_ex | sys_ex;
    assign int_sel_c       = pend_c & (~pend_c + INT_W'(1));
    assign int_ok_c        = status_in[0] && (depth_q == '0) && (|pend_c);
    assign nest_full_c     = (depth_q >= DEPTH_W'(MAX_NEST));

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        cp_d       = '0;
        epc_wr_d   = 1'b0;
        epc_val_d  = '0;
        flush_d    = 1'b0;
        pc_sel_d   = PC_SEQ;
        int_ack_d  = '0;
        depth_d    = depth_q;
        nest_err_d = nest_err_q;
        do_exc_c   = 1'b0;
        do_int_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exc_c) begin
                    if (nest_full_c) begin
                        nest_err_d = 1'b1;
                    end else begin
                        do_exc_c = 1'b1;
                    end
                end else if (eret) begin
                    nest_err_d = 1'b1;
                end else if (int_ok_c) begin
                    do_int_c = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (exc_c) begin
                    if (nest_full_c) begin
                        nest_err_d = 1'b1;
                    end else begin
                        do_exc_c = 1'b1;
                    end
                end else if (eret) begin
                    state_d  = ST_RETURN;
                    flush_d  = 1'b1;
                    pc_sel_d = PC_EPC;
                    depth_d  = depth_q - DEPTH_W'(1);
                end
            end
            ST_TAKE: begin
                state_d = ST_SERVICE;
            end
            ST_RETURN: begin
                state_d = (depth_q != '0) ? ST_SERVICE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_exc_c) begin
            state_d   = ST_TAKE;
            cp_d      = cause_onehot(ovf_ex, unimpl_ex, sys_ex);
            epc_wr_d  = 1'b1;
            epc_val_d = ex_pc;
            flush_d   = 1'b1;
            pc_sel_d  = PC_VECTOR;
            depth_d   = depth_q + DEPTH_W'(1);
        end else if (do_int_c) begin
            state_d   = ST_TAKE;
            cp_d      = '0;
            cp_d[CAUSE_INT] = 1'b1;
            epc_wr_d  = 1'b1;
            epc_val_d = nxt_pc;
            flush_d   = 1'b1;
            pc_sel_d  = PC_VECTOR;
            int_ack_d = int_sel_c;
            depth_d   = depth_q + DEPTH_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cp_q       <= '0;
            epc_wr_q   <= 1'b0;
            epc_val_q  <= '0;
            flush_q    <= 1'b0;
            pc_sel_q   <= PC_SEQ;
            int_ack_q  <= '0;
            depth_q    <= '0;
            nest_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cp_q       <= cp_d;
            epc_wr_q   <= epc_wr_d;
            epc_val_q  <= epc_val_d;
            flush_q    <= flush_d;
            pc_sel_q   <= pc_sel_d;
            int_ack_q  <= int_ack_d;
            depth_q    <= depth_d;
            nest_err_q <= nest_err_d;
        end
    end

    assign cp_signal = cp_q;
    assign epc_wr    = epc_wr_q;
    assign epc_val   = epc_val_q;
    assign flush     = flush_q;
    assign pc_sel    = pc_sel_q;
    assign int_ack   = int_ack_q;
    assign depth     = depth_q;
    assign nest_err  = nest_err_q;

endmodule

// File: tb/tb_exc_req_gen.sv
// Bench for exc_req_gen: directed scenarios plus random traffic against a nesting-stack model.
module tb_exc_req_gen;

    localparam int INT_W    = 4;
    localparam int MAX_NEST = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [INT_W-1:0]  int_req;
    logic              sys_ex, unimpl_ex, ovf_ex, eret;
    logic [31:0]       ex_pc, nxt_pc, status_in;
    logic [3:0]        cp_signal;
    logic              epc_wr;
    logic [31:0]       epc_val;
    logic              flush;
    logic [1:0]        pc_sel;
    logic [INT_W-1:0]  int_ack;
    logic [2:0]        depth;
    logic              nest_err;

    always #5 clk = ~clk;

    exc_req_gen #(.MAX_NEST(MAX_NEST), .INT_W(INT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .int_req   (int_req),
        .sys_ex    (sys_ex),
        .unimpl_ex (unimpl_ex),
        .ovf_ex    (ovf_ex),
        .eret      (eret),
        .ex_pc     (ex_pc),
        .nxt_pc    (nxt_pc),
        .status_in (status_in),
        .cp_signal (cp_signal),
        .epc_wr    (epc_wr),
        .epc_val   (epc_val),
        .flush     (flush),
        .pc_sel    (pc_sel),
        .int_ack   (int_ack),
        .depth     (depth),
        .nest_err  (nest_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: nesting level as a plain counter, the current cycle's pulse,
    // pending flags and a short history of sampled interrupt lines.
    int               m_depth;
    bit               m_nerr;
    logic [3:0]       m_cp;
    logic             m_epcwr;
    logic [31:0]      m_epc;
    logic             m_flush;
    logic [1:0]       m_pcsel;
    logic [INT_W-1:0] m_ack;
    logic [INT_W-1:0] m_pend;
    logic [INT_W-1:0] h1, h2, h3;

    function automatic void model_reset();
        m_depth = 0;  m_nerr = 0;
        m_cp = '0;    m_epcwr = 0; m_epc = '0;
        m_flush = 0;  m_pcsel = '0; m_ack = '0;
        m_pend = '0;  h1 = '0; h2 = '0; h3 = '0;
    endfunction

    function automatic void model_step();
        logic [INT_W-1:0] rise, eff, n_ack;
        logic [3:0]       n_cp;
        logic             n_epcwr, n_flush;
        logic [31:0]      n_epc;
        logic [1:0]       n_pcsel;
        int               sel;
        rise = h2 & ~h3;
        eff  = m_pend | rise;
        n_cp = '0; n_epcwr = 0; n_flush = 0; n_epc = '0; n_pcsel = 2'd0; n_ack = '0;
        if (!m_flush) begin
            if (ovf_ex || unimpl_ex || sys_ex) begin
                if (m_depth >= MAX_NEST) begin
                    m_nerr = 1;
                end else begin
                    n_cp    = ovf_ex ? 4'd8 : (unimpl_ex ? 4'd4 : 4'd2);
                    n_epcwr = 1; n_flush = 1; n_pcsel = 2'd1; n_epc = ex_pc;
                    m_depth = m_depth + 1;
                end
            end else if (eret) begin
                if (m_depth == 0) begin
                    m_nerr = 1;
                end else begin
                    n_flush = 1; n_pcsel = 2'd2;
                    m_depth = m_depth - 1;
                end
            end else if (m_depth == 0 && status_in[0] && eff != 0) begin
                sel = 0;
                for (int i = INT_W - 1; i >= 0; i--) if (eff[i]) sel = i;
                n_ack   = '0;
                n_ack[sel] = 1'b1;
                n_cp    = 4'd1;
                n_epcwr = 1; n_flush = 1; n_pcsel = 2'd1; n_epc = nxt_pc;
                m_depth = 1;
            end
        end
        m_pend = (m_pend & ~m_ack) | rise;
        h3 = h2; h2 = h1; h1 = int_req;
        m_cp = n_cp; m_epcwr = n_epcwr; m_epc = n_epc;
        m_flush = n_flush; m_pcsel = n_pcsel; m_ack = n_ack;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".cp"},       32'(cp_signal), 32'(m_cp));
        chk({tag, ".epc_wr"},   32'(epc_wr),    32'(m_epcwr));
        chk({tag, ".epc_val"},  epc_val,        m_epc);
        chk({tag, ".flush"},    32'(flush),     32'(m_flush));
        chk({tag, ".pc_sel"},   32'(pc_sel),    32'(m_pcsel));
        chk({tag, ".int_ack"},  32'(int_ack),   32'(m_ack));
        chk({tag, ".depth"},    32'(depth),     32'(m_depth));
        chk({tag, ".nest_err"}, 32'(nest_err),  32'(m_nerr));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        @(negedge clk);
        cmp_all(tag);
    endtask

    int takes;

    initial begin
        rst = 1'b0; int_req = '0; sys_ex = 0; unimpl_ex = 0; ovf_ex = 0; eret = 0;
        ex_pc = '0; nxt_pc = '0; status_in = '0;
        model_reset();
        cycle("reset");
        cycle("reset");
        rst = 1'b1;
        cycle("idle");
        cycle("idle");

        // Overflow in IDLE
        ovf_ex = 1; ex_pc = 32'h0040_0010;
        cycle("ovf");
        chk("t023_cp", 32'(cp_signal), 32'h8);
        chk("t023_epc", epc_val, 32'h0040_0010);
        chk("t023_pcsel", 32'(pc_sel), 32'h1);
        chk("t023_depth", 32'(depth), 32'h1);
        ovf_ex = 0;
        cycle("ovf_svc");
        eret = 1; cycle("ovf_ret");
        eret = 0; cycle("ovf_idle");

        // Interrupt line 2 with IE set
        int_req = 4'b0100; status_in = 32'h1; nxt_pc = 32'h0040_0020;
        cycle("irq2_a");
        cycle("irq2_b");
        cycle("irq2_take");
        chk("t024_cp", 32'(cp_signal), 32'h1);
        chk("t024_ack", 32'(int_ack), 32'h4);
        chk("t024_epc", epc_val, 32'h0040_0020);
        int_req = '0;
        cycle("irq2_svc");
        eret = 1; cycle("irq2_ret");
        eret = 0; cycle("irq2_idle");

        // Exception and eret together while servicing
        status_in = '0; sys_ex = 1; ex_pc = 32'h0000_1000;
        cycle("nest_a");
        sys_ex = 0; cycle("nest_svc");
        sys_ex = 1; eret = 1; ex_pc = 32'h0000_2000;
        cycle("nest_b");
        chk("t025_cp", 32'(cp_signal), 32'h2);
        chk("t025_depth", 32'(depth), 32'h2);
        chk("t025_pcsel", 32'(pc_sel), 32'h1);
        sys_ex = 0; eret = 0; cycle("nest_svc2");
        eret = 1; cycle("nest_r1");
        eret = 0; cycle("nest_s1");
        eret = 1; cycle("nest_r0");
        eret = 0; cycle("nest_idle");

        // Nesting overflow then full unwind
        takes = 0;
        for (int k = 0; k < 4; k++) begin
            sys_ex = 1; ex_pc = 32'h100 + 32'(k);
            cycle("ovfl_req");
            if (epc_wr) takes++;
            sys_ex = 0;
            cycle("ovfl_gap");
        end
        chk("t026_takes", 32'(takes), 32'd3);
        chk("t026_depth", 32'(depth), 32'd3);
        chk("t026_nerr", 32'(nest_err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            eret = 1; cycle("unwind_ret");
            chk("t026_pcsel", 32'(pc_sel), 32'h2);
            eret = 0; cycle("unwind_svc");
        end
        chk("t026_depth0", 32'(depth), 32'd0);

        // Masked interrupt is held pending until IE rises
        status_in = '0; int_req = 4'b0010; nxt_pc = 32'h0040_0030;
        for (int k = 0; k < 6; k++) cycle("mask_hold");
        chk("t027_noflush", 32'(flush), 32'd0);
        status_in = 32'h1;
        cycle("mask_take");
        chk("t027_ack", 32'(int_ack), 32'h2);
        int_req = '0; cycle("mask_svc");
        eret = 1; cycle("mask_ret");
        eret = 0; cycle("mask_idle");

        // Reset during TAKE clears outputs and all pending lines
        status_in = '0; int_req = 4'b1001;
        cycle("rst_pend"); cycle("rst_pend");
        int_req = '0;
        for (int k = 0; k < 4; k++) cycle("rst_pend");
        status_in = 32'h1;
        cycle("rst_take");
        chk("t028_ack", 32'(int_ack), 32'h1);
        #1 rst = 1'b0;
        #1 model_reset();
        cmp_all("rst_async");
        chk("t028_flush", 32'(flush), 32'd0);
        chk("t028_cp", 32'(cp_signal), 32'd0);
        chk("t028_depth", 32'(depth), 32'd0);
        @(negedge clk);
        cycle("rst_hold");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) cycle("rst_after");
        chk("t028_nopend", 32'(flush), 32'd0);

        // eret in IDLE is ignored but flagged
        eret = 1; cycle("idle_eret");
        eret = 0;
        chk("t016_nerr", 32'(nest_err), 32'd1);
        chk("t016_noflush", 32'(flush), 32'd0);
        cycle("idle_eret2");

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            rst       = (i == 400) ? 1'b0 : 1'b1;
            ovf_ex    = ($urandom_range(0, 15) == 0);
            unimpl_ex = ($urandom_range(0, 15) == 0);
            sys_ex    = ($urandom_range(0, 12) == 0);
            eret      = ($urandom_range(0, 5) == 0);
            for (int b = 0; b < INT_W; b++)
                if ($urandom_range(0, 7) == 0) int_req[b] = ~int_req[b];
            status_in = $urandom();
            status_in[0] = ($urandom_range(0, 3) != 0);
            ex_pc  = $urandom();
            nxt_pc = $urandom();
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
